// File: rtl/score_pulse_gen.sv
// Score pulse generator: queues hit points and feeds one count-enable pulse per point
// to the decimal score counter. Optional bonus input (doubled points) under SCORE_BONUS_EN.
module score_pulse_gen #(
  parameter int PEND_W    = 8,
  parameter int PTS_W     = 4,
  parameter int PULSE_GAP = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              hit_valid,
  input  logic [PTS_W-1:0]  hit_points,
  output logic              hit_ready,
  input  logic              counter_carry,
`ifdef SCORE_BONUS_EN
  input  logic              bonus,
`endif
  output logic              enable,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow
);

  localparam int SW = ((PEND_W > PTS_W + 1) ? PEND_W : PTS_W + 1) + 1;
  localparam int GW = (PULSE_GAP > 0) ? $clog2(PULSE_GAP + 1) : 1;
  localparam logic [SW-1:0] MAXP = SW'((2 ** PEND_W) - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t            r_state;
  logic              r_enable;
  logic              r_overflow;
  logic [PEND_W-1:0] r_pending;
  logic [GW-1:0]     r_gap;

  logic [PTS_W:0]    w_add;
  logic [PEND_W-1:0] w_rem;
  logic [SW-1:0]     w_sum;
  logic              w_accept;
  logic [PEND_W-1:0] w_pend_next;

`ifdef SCORE_BONUS_EN
  assign w_add = bonus ? {hit_points, 1'b0} : {1'b0, hit_points};
`else
  assign w_add = {1'b0, hit_points};
`endif

  // w_rem excludes the pulse already on the wire; it is what is still owed after this edge.
  assign w_rem       = r_pending - PEND_W'(r_enable);
  assign w_sum       = SW'(w_rem) + SW'(w_add);
  assign hit_ready   = !r_overflow && !clear && (w_sum <= MAXP);
  assign w_accept    = hit_valid && hit_ready;
  assign w_pend_next = w_rem + (w_accept ? PEND_W'(w_add) : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
      r_pending  <= '0;
      r_gap      <= '0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
      r_pending  <= '0;
      r_gap      <= '0;
    end else begin
      r_pending <= w_pend_next;
      if (counter_carry) begin
        r_overflow <= 1'b1;
        r_state    <= IDLE;
        r_enable   <= 1'b0;
      end else if (r_overflow) begin
        r_state  <= IDLE;
        r_enable <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_enable <= 1'b0;
            if (w_rem != '0) r_state <= PULSE;
          end
          PULSE: begin
            r_enable <= 1'b1;
            if (PULSE_GAP > 0) begin
              r_state <= GAP;
              r_gap   <= GW'(PULSE_GAP);
            end else if (w_pend_next > PEND_W'(1)) begin
              r_state <= PULSE;
            end else begin
              r_state <= IDLE;
            end
          end
          GAP: begin
            r_enable <= 1'b0;
            r_gap    <= r_gap - GW'(1);
            if (r_gap <= GW'(1)) r_state <= (w_rem != '0) ? PULSE : IDLE;
          end
          default: begin
            r_enable <= 1'b0;
            r_state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign enable   = r_enable;
  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign busy     = (r_pending != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_score_pulse_gen.sv
// Scoreboard bench for score_pulse_gen: one token per expected pulse is queued on accept
// and retired on each observed enable. Second instance exercises the inter-pulse gap.
module tb_score_pulse_gen;
  localparam int PW_A = 4;
  localparam int PW_B = 8;
  localparam int PT   = 4;

  logic clock = 1'b0, reset = 1'b0;
  logic clear = 1'b0, hit_valid = 1'b0, counter_carry = 1'b0;
  logic [PT-1:0] hit_points = '0;
  logic hit_ready, enable, busy, overflow;
  logic [PW_A-1:0] pending;

  logic vb = 1'b0;
  logic [PT-1:0] pb = '0;
  logic rdy_b, en_b, busy_b, ovf_b;
  logic [PW_B-1:0] pend_b;

`ifdef SCORE_BONUS_EN
  logic bonus = 1'b0;
`endif

  int total = 0, bad = 0;
  int sb[$];
  int pulses_a = 0;
  int hid = 0;

  always #5 clock = ~clock;

  score_pulse_gen #(.PEND_W(PW_A), .PTS_W(PT), .PULSE_GAP(0)) u_dut (
    .clock(clock), .reset(reset), .clear(clear), .hit_valid(hit_valid),
    .hit_points(hit_points), .hit_ready(hit_ready), .counter_carry(counter_carry),
`ifdef SCORE_BONUS_EN
    .bonus(bonus),
`endif
    .enable(enable), .pending(pending), .busy(busy), .overflow(overflow));

  score_pulse_gen #(.PEND_W(PW_B), .PTS_W(PT), .PULSE_GAP(2)) u_dut_gap (
    .clock(clock), .reset(reset), .clear(1'b0), .hit_valid(vb),
    .hit_points(pb), .hit_ready(rdy_b), .counter_carry(1'b0),
`ifdef SCORE_BONUS_EN
    .bonus(1'b0),
`endif
    .enable(en_b), .pending(pend_b), .busy(busy_b), .overflow(ovf_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Every pulse must retire one queued point.
  always @(negedge clock) begin
    if (reset && enable) begin
      pulses_a++;
      chk("sb_token", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int pts, input bit bon, input int limit);
    hit_valid  = 1'b1;
    hit_points = PT'(pts);
`ifdef SCORE_BONUS_EN
    bonus = bon;
`endif
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (hit_ready) begin
        hid++;
        for (int k = 0; k < (bon ? 2 * pts : pts); k++) sb.push_back(hid);
        @(posedge clock);
        #1;
        hit_valid = 1'b0;
`ifdef SCORE_BONUS_EN
        bonus = 1'b0;
`endif
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    hit_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      cyc(1);
      if (!busy && !enable) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_en(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (enable) return;
      cyc(1);
    end
    chk("enable_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int exp_en[6];
    int exp_pd[6];
    int rec[16];
    int f, s, cnt;
    exp_en = '{0, 0, 1, 1, 1, 0};
    exp_pd = '{3, 3, 3, 2, 1, 0};

    // Reset state
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(hit_ready), 1);

    // 3 points, back-to-back pulses starting two edges after accept
    p0 = pulses_a;
    send(3, 1'b0, 5);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc(1);
      chk($sformatf("t1_en%0d", k), 32'(enable), 32'(exp_en[k]));
      chk($sformatf("t1_pd%0d", k), 32'(pending), 32'(exp_pd[k]));
    end
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_pulses", 32'(pulses_a - p0), 3);

    // Zero-point hit: accepted, nothing happens
    p0 = pulses_a;
    send(0, 1'b0, 5);
    cyc(4);
    chk("zero_pending", 32'(pending), 0);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_pulses", 32'(pulses_a - p0), 0);

    // Gap instance: 2 points, pulses separated by 2 low cycles
    vb = 1'b1;
    pb = PT'(2);
    @(negedge clock);
    chk("gap_ready", 32'(rdy_b), 1);
    @(posedge clock);
    #1;
    vb = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) cyc(1);
      rec[k] = int'(en_b);
    end
    f = -1; s = -1; cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (rec[k] != 0) begin
        cnt++;
        if (f < 0) f = k;
        else if (s < 0) s = k;
      end
    end
    chk("gap_count", 32'(cnt), 2);
    chk("gap_first", 32'(f), 2);
    chk("gap_low_cycles", 32'(s - f - 1), 2);
    chk("gap_pend_end", 32'(pend_b), 0);

    // Near-full accumulator: 14 pending, 3 offered must wait
    p0 = pulses_a;
    send(14, 1'b0, 5);
    hit_valid  = 1'b1;
    hit_points = PT'(3);
    @(negedge clock);
    chk("full_ready", 32'(hit_ready), 0);
    send(3, 1'b0, 40);
    wait_idle(60);
    chk("full_pulses", 32'(pulses_a - p0), 17);
    chk("full_sb_empty", 32'(sb.size()), 0);

    // Hit coincident with a pulse at pending=2
    p0 = pulses_a;
    send(2, 1'b0, 5);
    for (int i = 0; i < 10 && !(enable && pending == PW_A'(2)); i++) cyc(1);
    chk("coinc_setup", 32'(enable && pending == PW_A'(2)), 1);
    hit_valid  = 1'b1;
    hit_points = PT'(5);
    #1;
    chk("coinc_ready", 32'(hit_ready), 1);
    hid++;
    for (int k = 0; k < 5; k++) sb.push_back(hid);
    @(posedge clock);
    #1;
    hit_valid = 1'b0;
    chk("coinc_pending", 32'(pending), 6);
    wait_idle(40);
    chk("coinc_pulses", 32'(pulses_a - p0), 7);
    chk("coinc_sb_empty", 32'(sb.size()), 0);

    // Carry mid-burst freezes scoring; clear (with a competing hit) recovers
    p0 = pulses_a;
    send(4, 1'b0, 5);
    wait_en(10);
    chk("ovf_pend_pre", 32'(pending), 4);
    counter_carry = 1'b1;
    cyc(1);
    counter_carry = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_enable", 32'(enable), 0);
    chk("ovf_ready", 32'(hit_ready), 0);
    chk("ovf_pending", 32'(pending), 3);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("ovf_hold_en", 32'(enable), 0);
      chk("ovf_hold_pd", 32'(pending), 3);
    end
    chk("ovf_pulses", 32'(pulses_a - p0), 1);
    clear      = 1'b1;
    hit_valid  = 1'b1;
    hit_points = PT'(2);
    #1;
    chk("clr_ready", 32'(hit_ready), 0);
    @(posedge clock);
    #1;
    clear     = 1'b0;
    hit_valid = 1'b0;
    #1;
    sb.delete();
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_pending", 32'(pending), 0);
    chk("clr_ready_after", 32'(hit_ready), 1);

    // Asynchronous reset mid-burst
    send(3, 1'b0, 5);
    wait_en(10);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_enable", 32'(enable), 0);
    chk("arst_pending", 32'(pending), 0);
    sb.delete();
    cyc(1);
    reset = 1'b1;
    p0 = pulses_a;
    cyc(5);
    chk("arst_pend_after", 32'(pending), 0);
    chk("arst_pulses", 32'(pulses_a - p0), 0);
    chk("arst_busy", 32'(busy), 0);

`ifdef SCORE_BONUS_EN
    p0 = pulses_a;
    send(3, 1'b1, 5);
    wait_idle(40);
    chk("bonus_pulses", 32'(pulses_a - p0), 6);
    chk("bonus_sb_empty", 32'(sb.size()), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
